// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, CDB source indices and small helpers for the result broadcast arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned ROB_WIDTH   = 4;

    localparam int unsigned CDB_SRC_ALU = 0;
    localparam int unsigned CDB_SRC_LSB = 1;
    localparam int unsigned CDB_SRC_BR  = 2;
    localparam int unsigned CDB_NUM_SRC = 3;

    // Round-robin successor of a granted source index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source circular FIFO holding results waiting for a CDB grant; flush empties it.
module cdb_src_queue #(
    parameter int unsigned Q_DEPTH = 2,
    parameter int unsigned WIDTH   = 68
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Q_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [Q_DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Q_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Q_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (do_pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[tail_q] <= data_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered common data bus between ALU, LSB and branch unit.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = CDB_NUM_SRC,
    parameter int unsigned DATA_W  = DATA_WIDTH,
    parameter int unsigned ADDR_W  = ADDR_WIDTH,
    parameter int unsigned ROB_W   = ROB_WIDTH,
    parameter int unsigned Q_DEPTH = 2,
    localparam int unsigned SrcW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      refresh_in,
    input  logic [NUM_SRC-1:0]        src_valid_in,
    output logic [NUM_SRC-1:0]        src_ready_out,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
    input  logic [NUM_SRC*ADDR_W-1:0] src_pc_in,
    input  logic [NUM_SRC*ROB_W-1:0]  src_rob_id_in,
    output logic                      cdb_valid_out,
    output logic [DATA_W-1:0]         cdb_data_out,
    output logic [ADDR_W-1:0]         cdb_pc_out,
    output logic [ROB_W-1:0]          cdb_rob_id_out,
    output logic [SrcW-1:0]           cdb_src_out,
    output logic                      busy_out
);

    localparam int unsigned EntW = DATA_W + ADDR_W + ROB_W;

    logic [NUM_SRC-1:0] full, empty, push, pop;
    logic [EntW-1:0]    head [NUM_SRC];
    logic               flush;

    logic               grant_valid;
    logic [SrcW-1:0]    winner;
    logic [EntW-1:0]    win_entry;
    int unsigned        scan_idx;

    logic [SrcW-1:0]    rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [ADDR_W-1:0]  cdb_pc_q, cdb_pc_d;
    logic [ROB_W-1:0]   cdb_rob_q, cdb_rob_d;
    logic [SrcW-1:0]    cdb_src_q, cdb_src_d;

    assign flush         = rdy_in && refresh_in;
    assign src_ready_out = ~full & {NUM_SRC{rdy_in}};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_queue
        // Entry layout: {data, pc, rob_id}.
        assign push[i] = rdy_in && !refresh_in && src_valid_in[i] && src_ready_out[i];
        assign pop[i]  = rdy_in && !refresh_in && grant_valid && (winner == SrcW'(i));

        cdb_src_queue #(
            .Q_DEPTH (Q_DEPTH),
            .WIDTH   (EntW)
        ) u_queue (
            .clk_i   (clk_in),
            .rst_ni  (rst_n_in),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .flush_i (flush),
            .data_i  ({src_data_in[i*DATA_W +: DATA_W],
                       src_pc_in[i*ADDR_W +: ADDR_W],
                       src_rob_id_in[i*ROB_W +: ROB_W]}),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    // First non-empty queue at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_SRC;
            if (!grant_valid && !empty[SrcW'(scan_idx)]) begin
                grant_valid = 1'b1;
                winner      = SrcW'(scan_idx);
            end
        end
    end

    assign win_entry = head[winner];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_data_d  = cdb_data_q;
        cdb_pc_d    = cdb_pc_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_src_d   = cdb_src_q;
        if (rdy_in) begin
            if (refresh_in) begin
                cdb_valid_d = 1'b0;
                rr_ptr_d    = '0;
            end else if (grant_valid) begin
                cdb_valid_d = 1'b1;
                {cdb_data_d, cdb_pc_d, cdb_rob_d} = win_entry;
                cdb_src_d   = winner;
                rr_ptr_d    = SrcW'(rr_next(32'(winner), NUM_SRC));
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_pc_q    <= '0;
            cdb_rob_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_pc_q    <= cdb_pc_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_data_out   = cdb_data_q;
    assign cdb_pc_out     = cdb_pc_q;
    assign cdb_rob_id_out = cdb_rob_q;
    assign cdb_src_out    = cdb_src_q;
    assign busy_out       = (~&empty) || cdb_valid_q;

endmodule
